pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the PC generator and its RAS.
// Optional feature macro: PC_GEN_RAS_EN (return-address stack).
package pc_pkg;

    localparam int PC_W_DEFAULT      = 32;
    localparam int STRIDE_DEFAULT    = 4;
    localparam int RAS_DEPTH_DEFAULT = 4;
    localparam logic [PC_W_DEFAULT-1:0] RESET_VEC_DEFAULT = '0;

    // Program-counter type at the default width. Modules with a
    // non-default PC_W use logic [PC_W-1:0] of the same shape.
    typedef logic [PC_W_DEFAULT-1:0] pc_t;

    // Fetch FSM: BOOT is the single cycle after reset release.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with write pointer and count.
// A push at full overwrites the oldest entry. Push and pop in the same
// cycle replace the top entry. A pop on empty is ignored.
// Instantiated by pc_gen only when PC_GEN_RAS_EN is defined.
module pc_ras
    import pc_pkg::*;
#(
    parameter int W     = PC_W_DEFAULT,
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_reg;      // next slot to write
    logic [CNT_W-1:0] cnt_reg;      // valid entries, saturates at DEPTH
    logic [PTR_W-1:0] top_idx;
    logic             do_pop;

    assign top_idx = ptr_reg - PTR_W'(1);
    assign do_pop  = pop && (cnt_reg != '0);
    assign top     = mem[top_idx];
    assign empty   = (cnt_reg == '0);

    // Pointer and count bookkeeping; replace-top leaves both unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else if (push && do_pop) begin
            ptr_reg <= ptr_reg;
            cnt_reg <= cnt_reg;
        end else if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (cnt_reg != CNT_W'(DEPTH)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_reg <= top_idx;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Entry storage; a simultaneous pop redirects the write onto the top slot.
    always_ff @(posedge clk) begin
        if (push) begin
            if (do_pop) begin
                mem[top_idx] <= push_data;
            end else begin
                mem[ptr_reg] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with valid/ready fetch handshake.
// Next-PC priority: trap > redirect > RAS return > sequential > hold.
// Non-sequential targets are aligned down to STRIDE; flushes apply
// regardless of stall/fetch_ready. Optional return-address stack is
// enabled with macro PC_GEN_RAS_EN; without it ras_empty is tied high.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              STRIDE    = STRIDE_DEFAULT,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            call_valid,
    input  logic [PC_W-1:0] call_ret_pc,
    input  logic            ret_valid,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_pc,
    input  logic            fetch_ready,
    output logic            ras_empty
);

    localparam logic [PC_W-1:0] STRIDE_PC  = PC_W'(STRIDE);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(STRIDE_PC - PC_W'(1));

    pc_state_e       state_reg;
    logic [PC_W-1:0] pc_reg;
    logic            valid_reg;
    logic [PC_W-1:0] pc_next;
    logic            advance;
    logic            ras_ret_take;
    logic [PC_W-1:0] ras_top;

    assign advance     = fetch_ready && !stall;
    assign fetch_pc    = pc_reg;
    assign fetch_valid = valid_reg;

`ifdef PC_GEN_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_empty_int;

    // Stack traffic only while fetching; a trap in the same cycle wins.
    assign ras_push     = (state_reg == RUN) && call_valid && !trap_valid;
    assign ras_pop      = (state_reg == RUN) && ret_valid && !ras_empty_int && !trap_valid;
    assign ras_ret_take = (state_reg == RUN) && ret_valid && !ras_empty_int;
    assign ras_empty    = ras_empty_int;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (call_ret_pc),
        .top       (ras_top),
        .empty     (ras_empty_int)
    );
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{call_valid, call_ret_pc, ret_valid};
    assign ras_ret_take      = 1'b0;
    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
`endif

    // Next-PC selection; BOOT only honours trap/redirect, else holds.
    always_comb begin
        pc_next = pc_reg;
        if (trap_valid) begin
            pc_next = trap_pc & ALIGN_MASK;
        end else if (redirect_valid) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (ras_ret_take) begin
            pc_next = ras_top & ALIGN_MASK;
        end else if ((state_reg == RUN) && advance) begin
            pc_next = pc_reg + STRIDE_PC;
        end
    end

    // Fetch FSM with registered valid and PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
            valid_reg <= 1'b0;
            pc_reg    <= RESET_VEC;
        end else begin
            pc_reg <= pc_next;
            case (state_reg)
                BOOT: begin
                    state_reg <= RUN;
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                    valid_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, handshake hold, priority/alignment,
// RAS behaviour (or its absence), mid-operation reset, BOOT redirect
// and 8-bit wrap on a second instance.
module tb_pc_gen;
    import pc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        call_valid;
    logic [31:0] call_ret_pc;
    logic        ret_valid;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        ras_empty;

    logic        r8_valid;
    logic [7:0]  r8_pc;
    logic        ready8;
    logic        valid8;
    logic [7:0]  pc8;
    logic        empty8;

    int vectors;
    int miscompares;

    pc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .call_valid     (call_valid),
        .call_ret_pc    (call_ret_pc),
        .ret_valid      (ret_valid),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .ras_empty      (ras_empty)
    );

    pc_gen #(.PC_W(8)) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (1'b0),
        .redirect_valid (r8_valid),
        .redirect_pc    (r8_pc),
        .trap_valid     (1'b0),
        .trap_pc        (8'h00),
        .call_valid     (1'b0),
        .call_ret_pc    (8'h00),
        .ret_valid      (1'b0),
        .fetch_valid    (valid8),
        .fetch_pc       (pc8),
        .fetch_ready    (ready8),
        .ras_empty      (empty8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_pc        = '0;
        call_valid     = 1'b0;
        call_ret_pc    = '0;
        ret_valid      = 1'b0;
        fetch_ready    = 1'b1;
        r8_valid       = 1'b0;
        r8_pc          = '0;
        ready8         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);

        // Release reset: cycle 0 is BOOT.
        rst_n = 1'b1;
        check("boot_valid", {31'b0, fetch_valid}, 32'h0);
        check("boot_pc", fetch_pc, 32'h0);
        step();
        check("run_valid", {31'b0, fetch_valid}, 32'h1);
        check("run_pc0", fetch_pc, 32'h0);
        step();
        check("seq_pc4", fetch_pc, 32'h4);
        step();
        check("seq_pc8", fetch_pc, 32'h8);

        // Handshake hold.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        check("redir_lat1", fetch_pc, 32'h10);
        redirect_valid = 1'b0;
        fetch_ready    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_not_ready", fetch_pc, 32'h10);
        end
        fetch_ready = 1'b1;
        step();
        check("accept_after_hold", fetch_pc, 32'h14);
        stall = 1'b1;
        step();
        check("hold_stall", fetch_pc, 32'h14);

        // Priority and alignment while stalled.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        trap_valid     = 1'b1;
        trap_pc        = 32'h200;
        step();
        check("trap_over_redir", fetch_pc, 32'h200);
        trap_valid = 1'b0;
        step();
        check("redir_aligned", fetch_pc, 32'h100);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        check("seq_after_redir", fetch_pc, 32'h104);

`ifdef PC_GEN_RAS_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        check("ras_base", fetch_pc, 32'h300);
        redirect_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            call_valid  = 1'b1;
            call_ret_pc = 32'(i * 16);
            step();
            check("call_seq_pc", fetch_pc, 32'(32'h300 + i * 4));
        end
        call_valid = 1'b0;
        check("ras_not_empty", {31'b0, ras_empty}, 32'h0);
        ret_valid = 1'b1;
        step();
        check("ret1", fetch_pc, 32'h50);
        step();
        check("ret2", fetch_pc, 32'h40);
        step();
        check("ret3", fetch_pc, 32'h30);
        step();
        check("ret4", fetch_pc, 32'h20);
        check("ras_drained", {31'b0, ras_empty}, 32'h1);
        step();
        check("ret_empty_seq", fetch_pc, 32'h24);
        check("ret_empty_flag", {31'b0, ras_empty}, 32'h1);
        ret_valid = 1'b0;

        // Simultaneous call and return replaces the top.
        call_valid  = 1'b1;
        call_ret_pc = 32'h80;
        step();
        check("push80_seq", fetch_pc, 32'h28);
        call_ret_pc = 32'h90;
        ret_valid   = 1'b1;
        step();
        check("callret_pc", fetch_pc, 32'h80);
        check("callret_nonempty", {31'b0, ras_empty}, 32'h0);
        call_valid = 1'b0;
        step();
        check("new_top", fetch_pc, 32'h90);
        check("count_one", {31'b0, ras_empty}, 32'h1);
        step();
        check("ret_empty_seq2", fetch_pc, 32'h94);
        ret_valid = 1'b0;

        // Trap blocks a push.
        call_valid  = 1'b1;
        call_ret_pc = 32'hA0;
        trap_valid  = 1'b1;
        trap_pc     = 32'h400;
        step();
        check("trap_pc", fetch_pc, 32'h400);
        check("trap_no_push", {31'b0, ras_empty}, 32'h1);
        call_valid = 1'b0;
        trap_valid = 1'b0;
`else
        // Without the RAS, call/ret have no effect.
        call_valid  = 1'b1;
        call_ret_pc = 32'h80;
        ret_valid   = 1'b1;
        step();
        check("noras_seq1", fetch_pc, 32'h108);
        check("noras_empty", {31'b0, ras_empty}, 32'h1);
        step();
        check("noras_seq2", fetch_pc, 32'h10C);
        call_valid = 1'b0;
        ret_valid  = 1'b0;
`endif

        // Reset mid-operation discards an in-flight redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        rst_n          = 1'b0;
        #1;
        check("async_rst_pc", fetch_pc, 32'h0);
        check("async_rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("async_rst_empty", {31'b0, ras_empty}, 32'h1);
        step();
        check("rst_held_pc", fetch_pc, 32'h0);

        // Redirect during BOOT loads the target and still enters RUN.
        rst_n          = 1'b1;
        redirect_pc    = 32'h44;
        r8_valid       = 1'b1;
        r8_pc          = 8'hFC;
        check("boot2_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        check("boot_redir_pc", fetch_pc, 32'h44);
        check("boot_redir_valid", {31'b0, fetch_valid}, 32'h1);
        check("pc8_loaded", {24'b0, pc8}, 32'hFC);
        check("pc8_valid", {31'b0, valid8}, 32'h1);
        redirect_valid = 1'b0;
        r8_valid       = 1'b0;
        ready8         = 1'b1;
        step();
        check("after_boot_seq", fetch_pc, 32'h48);
        check("pc8_wrap", {24'b0, pc8}, 32'h00);
        step();
        check("pc8_after_wrap", {24'b0, pc8}, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
